mem_zetas_seq: RTL

- Parametrised zeta sequencer for the ML-KEM NTT unit. It supersedes the plain addressed zeta ROM.
- It holds the 128-entry Montgomery-domain zeta table internally and walks it autonomously for one of three modes:
  - forward NTT,
  - inverse NTT,
  - base multiplication.
- It streams one zeta per beat to the butterfly datapath over a valid/ready handshake, and can optionally repeat or negate values.
- It sits between the NTT control FSM (start/done) and the butterfly core.

---
 rtl/mlkem_pkg.sv | 26 ++
 rtl/zeta_rom.sv | 40 ++++
 rtl/mem_zetas_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mlkem_pkg.sv
// Shared ML-KEM constants and encodings for the NTT zeta path.
//   MLKEM_Q     modulus used for zeta negation
//   MLKEM_N     polynomial length
//   ZETA_DEPTH  number of entries in the zeta table
//   mode_e      operation select seen on the sequencer mode port
//   state_e     zeta sequencer FSM state encoding
package mlkem_pkg;

  localparam int MLKEM_Q    = 3329;
  localparam int MLKEM_N    = 256;
  localparam int ZETA_DEPTH = MLKEM_N / 2;

  typedef enum logic [1:0] {
    MODE_NTT     = 2'd0,
    MODE_INTT    = 2'd1,
    MODE_BASEMUL = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_STREAM = 2'd2
  } state_e;

endpackage

// File: rtl/zeta_rom.sv
// Zeta table in Montgomery form (z * 2^16 mod Q), synchronous read with a
// registered output: data follows addr one clock later.
//   clk   clock
//   addr  table index
//   data  table entry, unsigned, always in [1, Q-1]
module zeta_rom
  import mlkem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int ZETAS [ZETA_DEPTH] = '{
    2285, 2571, 2970, 1812, 1493, 1422,  287,  202,
    3158,  622, 1577,  182,  962, 2127, 1855, 1468,
     573, 2004,  264,  383, 2500, 1458, 1727, 3199,
    2648, 1017,  732,  608, 1787,  411, 3124, 1758,
    1223,  652, 2777, 1015, 2036, 1491, 3047, 1785,
     516, 3321, 3009, 2663, 1711, 2167,  126, 1469,
    2476, 3239, 3058,  830,  107, 1908, 3082, 2378,
    2931,  961, 1821, 2604,  448, 2264,  677, 2054,
    2226,  430,  555,  843, 2078,  871, 1550,  105,
     422,  587,  177, 3094, 3038, 2869, 1574, 1653,
    3083,  778, 1159, 3182, 2552, 1483, 2727, 1119,
    1739,  644, 2457,  349,  418,  329, 3173, 3254,
     817, 1097,  603,  610, 1322, 2044, 1864,  384,
    2114, 3193, 1218, 1994, 2455,  220, 2142, 1670,
    2144, 1799, 2051,  794, 1819, 2475, 2459,  478,
    3221, 3021,  996,  991,  958, 1869, 1522, 1628
  };

  always_ff @(posedge clk) begin
    data <= DATA_WIDTH'(ZETAS[addr]);
  end

endmodule

// File: rtl/mem_zetas_seq.sv
// Zeta sequencer for the ML-KEM NTT unit. Walks the internal zeta table for
// forward NTT, inverse NTT or base multiplication and streams one zeta per
// beat over a valid/ready handshake.
//   clk, rst          clock, synchronous active-high reset
//   start, mode       run request (accepted in IDLE only) and operation select
//   busy              run in progress (PRIME and STREAM)
//   zeta_valid/ready  beat handshake towards the butterfly core
//   zeta_out          zeta value, Q-z where negation applies
//   zeta_idx, layer   table index and NTT layer of the current beat
//   zeta_last         qualifies the final beat of the stream
//   done              one-cycle pulse after the final handshake
//   err               one-cycle pulse after a start with the reserved mode
//
// state     | meaning
// ST_IDLE   | waiting for start; ROM address tracks the first index of mode
// ST_PRIME  | first table read in flight
// ST_STREAM | zeta_valid high; a beat completes on zeta_valid && zeta_ready
module mem_zetas_seq
  import mlkem_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int Q          = MLKEM_Q,
  parameter bit PER_BF     = 1'b1,
  parameter bit INV_NEG    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mode,
  output logic                  busy,
  output logic                  zeta_valid,
  input  logic                  zeta_ready,
  output logic [DATA_WIDTH-1:0] zeta_out,
  output logic [ADDR_WIDTH-1:0] zeta_idx,
  output logic [2:0]            layer,
  output logic                  zeta_last,
  output logic                  done,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_TOP  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_HALF = ADDR_WIDTH'(DEPTH / 2);

  state_e                  state_q, state_d;
  mode_e                   mode_q;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_nxt, rom_addr;
  logic [2:0]              layer_q, layer_nxt;
  // Beats still to be issued on the current index after this one.
  logic [ADDR_WIDTH-1:0]   rep_q;
  logic                    done_q, err_q;
  logic [DATA_WIDTH-1:0]   rom_data;
  logic                    start_ok, beat, last_beat, negate;

  function automatic logic [ADDR_WIDTH-1:0] first_idx(input mode_e m);
    case (m)
      MODE_INTT:    return IDX_TOP;
      MODE_BASEMUL: return IDX_HALF;
      default:      return IDX_ONE;
    endcase
  endfunction

  // Repeat count (minus one) for every index of a given layer.
  function automatic logic [ADDR_WIDTH-1:0] beats_minus1(input mode_e m,
                                                         input logic [2:0] l);
    case (m)
      MODE_NTT:     return PER_BF ? ADDR_WIDTH'((DEPTH >> l) - 1) : '0;
      MODE_INTT:    return PER_BF ? ADDR_WIDTH'((2 << l) - 1) : '0;
      MODE_BASEMUL: return IDX_ONE;
      default:      return '0;
    endcase
  endfunction

  zeta_rom #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_rom (
    .clk (clk),
    .addr(rom_addr),
    .data(rom_data)
  );

  // Layer boundaries fall on powers of two: NTT finishes a layer on an index
  // of the form 2^k-1, INTT finishes one on an index 2^k.
  always_comb begin
    idx_nxt   = idx_q;
    layer_nxt = layer_q;
    last_beat = 1'b0;
    case (mode_q)
      MODE_NTT: begin
        idx_nxt   = idx_q + IDX_ONE;
        if ((idx_q & idx_nxt) == '0) layer_nxt = layer_q + 3'd1;
        last_beat = (idx_q == IDX_TOP) && (rep_q == '0);
      end
      MODE_INTT: begin
        idx_nxt   = idx_q - IDX_ONE;
        if ((idx_q & idx_nxt) == '0) layer_nxt = layer_q + 3'd1;
        last_beat = (idx_q == IDX_ONE) && (rep_q == '0);
      end
      MODE_BASEMUL: begin
        idx_nxt   = idx_q + IDX_ONE;
        last_beat = (idx_q == IDX_TOP) && (rep_q == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start_ok   = 1'b0;
    busy       = 1'b0;
    zeta_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (mode != MODE_RSVD)) begin
          start_ok = 1'b1;
          state_d  = ST_PRIME;
        end
      end
      ST_PRIME: begin
        busy    = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        busy       = 1'b1;
        zeta_valid = 1'b1;
        if (zeta_ready && last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign beat = zeta_valid && zeta_ready;

  // The ROM always reads the index that will be on the outputs next cycle,
  // so back-to-back beats need no bubble and a stall holds the data.
  always_comb begin
    rom_addr = idx_q;
    if (state_q == ST_IDLE)         rom_addr = first_idx(mode_e'(mode));
    else if (beat && rep_q == '0)   rom_addr = idx_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_NTT;
      idx_q   <= '0;
      layer_q <= '0;
      rep_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= beat && last_beat;
      err_q  <= (state_q == ST_IDLE) && start && (mode == MODE_RSVD);
      if (start_ok) begin
        mode_q  <= mode_e'(mode);
        idx_q   <= first_idx(mode_e'(mode));
        layer_q <= '0;
        rep_q   <= beats_minus1(mode_e'(mode), 3'd0);
      end else if (beat) begin
        if (rep_q != '0) begin
          rep_q <= rep_q - IDX_ONE;
        end else begin
          idx_q   <= idx_nxt;
          layer_q <= layer_nxt;
          rep_q   <= beats_minus1(mode_q, layer_nxt);
        end
      end
    end
  end

  // BASEMUL issues +z first and Q-z on the second (final) repeat.
  assign negate = ((mode_q == MODE_INTT) && INV_NEG) ||
                  ((mode_q == MODE_BASEMUL) && (rep_q == '0));

  always_comb begin
    zeta_out  = '0;
    zeta_idx  = '0;
    layer     = '0;
    zeta_last = 1'b0;
    if (zeta_valid) begin
      zeta_out  = negate ? (DATA_WIDTH'(Q) - rom_data) : rom_data;
      zeta_idx  = idx_q;
      layer     = layer_q;
      zeta_last = last_beat;
    end
  end

  assign done = done_q;
  assign err  = err_q;

endmodule
